// File: rtl/key_entry_debounce.sv
// Enter-key debouncer and digit capture for the lock keypad.
// Synchronizes the raw key and switches, debounces the key and hands each press to the lock FSM.
module key_entry_debounce #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [3:0] sw,
  output logic [3:0] digit,
  output logic       digit_err,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic       key_level,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  logic             key_s1_q, key_s2_q;
  logic [3:0]       sw_s1_q, sw_s2_q;
  logic             db_n_q, db_n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;
  state_e           state_q, state_d;
  logic             capture, set_ovr;
  logic [3:0]       digit_q;
  logic             err_q, ovr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      sw_s1_q  <= 4'd0;
      sw_s2_q  <= 4'd0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      sw_s1_q  <= sw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // The counter counts consecutive disagreeing edges; it is cleared on agreement and on update,
  // so it never passes CntMax.
  always_comb begin
    cnt_d  = cnt_q;
    db_n_d = db_n_q;
    if (key_s2_q == db_n_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d  = '0;
      db_n_d = key_s2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign press = db_n_q & ~db_n_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      db_n_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      db_n_q <= db_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    set_ovr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StHold;
          capture = 1'b1;
        end
      end
      StHold: begin
        // A press landing on the accepting edge replaces the entry instead of overrunning.
        if (press) begin
          if (digit_ready) capture = 1'b1;
          else             set_ovr = 1'b1;
        end else if (digit_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      digit_q <= 4'd0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        digit_q <= sw_s2_q;
        err_q   <= (sw_s2_q > 4'd9);
      end
      if (set_ovr) ovr_q <= 1'b1;
    end
  end

  assign digit       = digit_q;
  assign digit_err   = err_q;
  assign digit_valid = (state_q == StHold);
  assign key_level   = ~db_n_q;
  assign overrun     = ovr_q;

  cnt_bound_a: assert property (@(posedge clk) disable iff (!reset) cnt_q <= CntMax);
  ovr_sticky_a: assert property (@(posedge clk) disable iff (!reset) ovr_q |=> ovr_q);

endmodule

// File: doc/key_entry_debounce.md
KEY_ENTRY_DEBOUNCE -- requirements
Module: key_entry_debounce

Interface
REQ-001 Parameter: DB_CYCLES, default 1000000, number of consecutive clocks a synchronized key level must differ from the debounced level before it is accepted (20 ms at 50 MHz); SHALL be >= 2.
REQ-002 Parameter: CNT_W, default 20, debounce counter width; SHALL satisfy 2^CNT_W >= DB_CYCLES.
REQ-003 Port: clk  input  1  the single system clock; all flops SHALL be on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port: key_n  input  1  raw, asynchronous, bouncing enter pushbutton, active-low (0 = pressed).
REQ-006 Port: sw  input  4  raw, asynchronous digit switches.
REQ-007 Port: digit  output  4  captured digit presented to the lock FSM.
REQ-008 Port: digit_err  output  1  captured digit is non-decimal (> 9).
REQ-009 Port: digit_valid  output  1  digit/digit_err hold a pending entry.
REQ-010 Port: digit_ready  input  1  lock FSM accepts the entry this cycle.
REQ-011 Port: key_level  output  1  debounced pressed level, active-high.
REQ-012 Port: overrun  output  1  sticky: a press was dropped because an entry was still pending.

Function
REQ-013 key_n and sw SHALL each pass through a 2-flop synchronizer; key_n sync flops reset to 1, sw sync flops reset to 0.
REQ-014 Debounced level db_n (reset 1) SHALL update to the synchronized key value on the DB_CYCLES-th consecutive edge at which they differ; any edge with equality clears the counter to 0.
REQ-015 key_level SHALL equal ~db_n.
REQ-016 Press event: the edge at which db_n changes 1->0; release (0->1) SHALL generate no event.
REQ-017 Latency: for a clean key_n fall before edge 1, key_level and digit_valid SHALL rise at edge 2+DB_CYCLES.
REQ-018 On a press event, digit SHALL capture the synchronized sw value at that same edge; digit_err SHALL be registered as (captured value > 9).
REQ-019 Handshake FSM, two states: IDLE (digit_valid=0) and HOLD (digit_valid=1).
REQ-020 IDLE + press event -> HOLD with new digit captured.
REQ-021 HOLD + digit_ready=1, no press event -> IDLE at that edge; digit and digit_err retain their values.
REQ-022 HOLD + digit_ready=1 + press event on the same edge -> stay HOLD, capture the new digit; overrun SHALL NOT be set.
REQ-023 HOLD + digit_ready=0 + press event -> stay HOLD, keep the old digit, set overrun to 1.
REQ-024 overrun SHALL clear only on reset.
REQ-025 digit_ready SHALL be ignored in IDLE.
REQ-026 The counter SHALL saturate-free wrap never occur: it SHALL be cleared on every db_n update, so it never exceeds DB_CYCLES-1.

Reset
REQ-027 While reset=0, asynchronously: digit=0, digit_err=0, digit_valid=0, key_level=0, overrun=0, counter=0, db_n=1, FSM=IDLE.
REQ-028 Reset asserted mid-debounce or with an entry pending SHALL discard all progress and the pending entry; after release, a key already held low SHALL be re-debounced from count 0 and produce one press event.

Verification (DB_CYCLES=4)
REQ-029 Reset low with key_n=0, sw=5 -> all outputs 0; release reset -> digit_valid=1, digit=5 at edge 6.
REQ-030 sw=7, key_n low 20 cycles, digit_ready=1 -> digit_valid high exactly one cycle at edge 6, digit=7, digit_err=0, key_level high until 6 edges after release; release produces no second pulse.
REQ-031 key_n glitches low for 3 cycles, high for 2, low for 3, then high -> digit_valid and key_level never assert.
REQ-032 sw=4'b1100 press -> digit=12, digit_err=1, digit_valid=1.
REQ-033 digit_ready=0: press sw=7, then press sw=2 -> digit stays 7, overrun=1; then digit_ready=1 for one cycle -> digit_valid=0 next cycle, overrun remains 1.
REQ-034 Press completes on the same edge digit_ready=1 for a pending entry -> digit_valid stays 1, digit updates to the new value, overrun=0.
